// File: rtl/resample_addr_gen.sv
// Nearest-neighbour resample address generator: addr[i] = base + round(i * ratio), 2-stage pipe.
// Optional out_frac port (pre-rounding fraction) is enabled by defining RESAMPLE_FRAC_OUT_EN.
module resample_addr_gen #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned RATIO_W    = 17,
  parameter int unsigned RATIO_FRAC = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [RATIO_W-1:0]    ratio,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       length,
  input  logic                  round_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  out_last,
`ifdef RESAMPLE_FRAC_OUT_EN
  output logic [RATIO_FRAC-1:0] out_frac,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned PW = ADDR_W + RATIO_W;
  localparam logic [PW:0] RndHalf = (PW+1)'(1) << (RATIO_FRAC - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e              state_q, state_d;
  logic [RATIO_W-1:0]  ratio_q, ratio_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                mode_q, mode_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic                s1_valid_q, s1_valid_d;
  logic [PW-1:0]       s1_prod_q, s1_prod_d;
  logic                s1_last_q, s1_last_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
`ifdef RESAMPLE_FRAC_OUT_EN
  logic [RATIO_FRAC-1:0] frac_q, frac_d;
`endif

  logic                en;
  logic [ADDR_W:0]     last_idx;
  logic [PW:0]         sum;
  logic [PW:0]         q_wide;

  always_comb begin
    en       = !valid_q || out_ready;
    last_idx = len_q - (ADDR_W+1)'(1);
    sum      = {1'b0, s1_prod_q} + (mode_q ? RndHalf : '0);
    q_wide   = sum >> RATIO_FRAC;

    state_d    = state_q;
    ratio_d    = ratio_q;
    base_d     = base_q;
    mode_d     = mode_q;
    len_d      = len_q;
    idx_d      = idx_q;
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_last_d  = s1_last_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    last_d     = last_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
`ifdef RESAMPLE_FRAC_OUT_EN
    frac_d     = frac_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ovf_d = 1'b0;
          if (length != '0) begin
            ratio_d = ratio;
            base_d  = base_addr;
            mode_d  = round_mode;
            len_d   = length;
            idx_d   = '0;
            state_d = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (en) begin
          if (idx_q == last_idx) state_d = StDrain;
          else                   idx_d   = idx_q + (ADDR_W+1)'(1);
        end
      end
      StDrain: begin
        if (valid_q && out_ready && last_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Both stages advance together; a stalled output freezes the whole pipe.
    if (en) begin
      s1_valid_d = (state_q == StRun);
      s1_prod_d  = PW'(idx_q) * PW'(ratio_q);
      s1_last_d  = (state_q == StRun) && (idx_q == last_idx);
      valid_d    = s1_valid_q;
      if (s1_valid_q) begin
        addr_d = base_q + q_wide[ADDR_W-1:0];
        last_d = s1_last_q;
`ifdef RESAMPLE_FRAC_OUT_EN
        frac_d = s1_prod_q[RATIO_FRAC-1:0];
`endif
        if (|q_wide[PW:ADDR_W]) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ratio_q    <= '0;
      base_q     <= '0;
      mode_q     <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_last_q  <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef RESAMPLE_FRAC_OUT_EN
      frac_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ratio_q    <= ratio_d;
      base_q     <= base_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_last_q  <= s1_last_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
`ifdef RESAMPLE_FRAC_OUT_EN
      frac_q     <= frac_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign overflow  = ovf_q;
`ifdef RESAMPLE_FRAC_OUT_EN
  assign out_frac  = frac_q;
`endif

endmodule

// File: tb/tb_resample_addr_gen.sv
// Directed self-checking bench for resample_addr_gen at default parameters.
module tb_resample_addr_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [16:0] ratio = '0;
  logic [10:0] base_addr = '0;
  logic [11:0] length = '0;
  logic        round_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [10:0] out_addr;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        overflow;
`ifdef RESAMPLE_FRAC_OUT_EN
  logic [15:0] out_frac;
`endif

  always #5 clk = ~clk;

  resample_addr_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .ratio      (ratio),
    .base_addr  (base_addr),
    .length     (length),
    .round_mode (round_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_last   (out_last),
`ifdef RESAMPLE_FRAC_OUT_EN
    .out_frac   (out_frac),
`endif
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [10:0] got_addr[$];
  bit          got_last[$];
  bit          got_ovf[$];
  int first_valid_cyc, last_acc_cyc, done_cyc, done_cnt, stall_err;
  bit timed_out, busy0, ovf0;

  logic [10:0] exp_wrap [12] = '{11'h7F0, 11'h7F1, 11'h7F3, 11'h7F4, 11'h7F6, 11'h7F7,
                                 11'h7F9, 11'h7FA, 11'h7FC, 11'h7FD, 11'h7FF, 11'h000};
  logic [10:0] exp_trunc [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  logic [10:0] exp_near  [8] = '{0, 1, 1, 2, 2, 3, 3, 4};

  // Drives one run and records accepted beats; cyc counts edges after the start edge.
  // poke: 0 none, 1 extra start mid-run (base 0x100), 2 start on the final accept.
  task automatic do_run(input logic [16:0] r, input logic [10:0] b, input logic [11:0] len,
                        input logic m, input bit toggle, input int poke, input int budget);
    logic [10:0] held_addr;
    bit held_last, stalled;
    int cyc;
    got_addr.delete(); got_last.delete(); got_ovf.delete();
    first_valid_cyc = -1; last_acc_cyc = -1; done_cyc = -1; done_cnt = 0; stall_err = 0;
    held_addr = '0; held_last = 1'b0; stalled = 1'b0;
    @(negedge clk);
    ratio = r; base_addr = b; length = len; round_mode = m; start = 1'b1; out_ready = 1'b1;
    cyc = -1;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      base_addr = b;
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (cyc == 0) begin busy0 = busy; ovf0 = overflow; end
      if (stalled && (!out_valid || out_addr !== held_addr || out_last !== held_last))
        stall_err++;
      stalled = out_valid && !out_ready;
      held_addr = out_addr;
      held_last = out_last;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_last.push_back(out_last);
        got_ovf.push_back(overflow);
        if (out_last) begin
          last_acc_cyc = cyc;
          if (poke == 2) start = 1'b1;
        end
      end
      if (poke == 1 && cyc == 5) begin start = 1'b1; base_addr = 11'h100; end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    timed_out = (done_cyc < 0);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_addr !== 11'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", out_addr); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", out_last); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Unity ratio; toggle selects ready 1,0,1,0; poke as in do_run.
  task automatic test_unity(input string nm, input bit toggle, input int poke);
    do_run(17'h10000, 11'h000, 12'd16, 1'b0, toggle, poke, 200);
    n_cmp++; if (timed_out) begin n_err++; $display("FAIL %s_timeout: got no done want done", nm); end
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL %s_busy: got %b want 1", nm, busy0); end
    n_cmp++; if (got_addr.size() != 16) begin n_err++; $display("FAIL %s_count: got %0d want 16", nm, got_addr.size()); end
    for (int i = 0; i < 16 && i < got_addr.size(); i++) begin
      n_cmp++;
      if (got_addr[i] !== 11'(i) || got_last[i] !== (i == 15)) begin
        n_err++;
        $display("FAIL %s_beat[%0d]: got addr %h last %b want addr %h last %b", nm, i, got_addr[i],
                 got_last[i], 11'(i), (i == 15));
      end
    end
    n_cmp++; if (first_valid_cyc != 2) begin n_err++; $display("FAIL %s_latency: got %0d want 2", nm, first_valid_cyc); end
    if (!toggle) begin
      n_cmp++; if (last_acc_cyc != 17) begin n_err++; $display("FAIL %s_last_cyc: got %0d want 17", nm, last_acc_cyc); end
    end
    n_cmp++; if (done_cyc != last_acc_cyc + 1) begin n_err++; $display("FAIL %s_done_cyc: got %0d want %0d", nm, done_cyc, last_acc_cyc + 1); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL %s_done_cnt: got %0d want 1", nm, done_cnt); end
    n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL %s_stall: got %0d unstable cycles want 0", nm, stall_err); end
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL %s_idle: got busy %b valid %b want 0 0", nm, busy, out_valid); end
  endtask

  task automatic test_half(input logic m);
    do_run(17'h08000, 11'h000, 12'd8, m, 1'b0, 0, 100);
    n_cmp++; if (got_addr.size() != 8 || timed_out) begin n_err++; $display("FAIL half%0d_count: got %0d want 8", m, got_addr.size()); end
    for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
      n_cmp++;
      if (got_addr[i] !== (m ? exp_near[i] : exp_trunc[i])) begin
        n_err++;
        $display("FAIL half%0d_addr[%0d]: got %h want %h", m, i, got_addr[i], (m ? exp_near[i] : exp_trunc[i]));
      end
    end
  endtask

  task automatic test_wrap();
    do_run(17'h18000, 11'h7F0, 12'd12, 1'b0, 1'b0, 0, 100);
    n_cmp++; if (got_addr.size() != 12 || timed_out) begin n_err++; $display("FAIL wrap_count: got %0d want 12", got_addr.size()); end
    for (int i = 0; i < 12 && i < got_addr.size(); i++) begin
      n_cmp++;
      if (got_addr[i] !== exp_wrap[i] || got_ovf[i] !== 1'b0) begin
        n_err++;
        $display("FAIL wrap_addr[%0d]: got %h ovf %b want %h ovf 0", i, got_addr[i], got_ovf[i], exp_wrap[i]);
      end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wrap_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    int first_ovf, n_ovf;
    do_run(17'h1FFFF, 11'h000, 12'd2048, 1'b0, 1'b0, 0, 2300);
    n_cmp++; if (got_addr.size() != 2048 || timed_out) begin n_err++; $display("FAIL ovf_count: got %0d want 2048", got_addr.size()); end
    first_ovf = -1; n_ovf = 0;
    foreach (got_ovf[i]) begin
      if (got_ovf[i]) begin
        n_ovf++;
        if (first_ovf < 0) first_ovf = i;
      end
    end
    n_cmp++; if (first_ovf != 1025) begin n_err++; $display("FAIL ovf_first: got %0d want 1025", first_ovf); end
    n_cmp++; if (n_ovf != 1023) begin n_err++; $display("FAIL ovf_sticky: got %0d want 1023", n_ovf); end
    if (got_addr.size() == 2048) begin
      n_cmp++; if (got_addr[1024] !== 11'd2047) begin n_err++; $display("FAIL ovf_a1024: got %h want 7ff", got_addr[1024]); end
      n_cmp++; if (got_addr[1025] !== 11'd1) begin n_err++; $display("FAIL ovf_a1025: got %h want 001", got_addr[1025]); end
      n_cmp++; if (got_addr[2047] !== 11'd2045) begin n_err++; $display("FAIL ovf_a2047: got %h want 7fd", got_addr[2047]); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_hold: got %b want 1", overflow); end
    do_run(17'h10000, 11'h000, 12'd4, 1'b0, 1'b0, 0, 100);
    n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", ovf0); end
  endtask

  task automatic test_reset_midrun();
    bit found, bad;
    @(negedge clk);
    ratio = 17'h10000; base_addr = '0; length = 12'd16; round_mode = 1'b0; out_ready = 1'b1;
    start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_addr === 11'd5) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL rst_mid_beat5: got none want beat 5"); end
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_addr !== 11'h0) begin
      n_err++;
      $display("FAIL rst_mid_clear: got valid %b busy %b done %b addr %h want 0 0 0 000",
               out_valid, busy, done, out_addr);
    end
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || out_valid || busy) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_err++; $display("FAIL rst_mid_quiet: got activity after reset want none"); end
    do_run(17'h10000, 11'h000, 12'd0, 1'b0, 1'b0, 0, 20);
    n_cmp++; if (done_cyc != 0 || done_cnt != 1) begin n_err++; $display("FAIL len0_done: got cyc %0d cnt %0d want 0 1", done_cyc, done_cnt); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL len0_busy: got %b want 0", busy0); end
    n_cmp++; if (got_addr.size() != 0 || first_valid_cyc != -1) begin n_err++; $display("FAIL len0_beats: got %0d want 0", got_addr.size()); end
  endtask

  initial begin
    test_reset();
    test_unity("unity", 1'b0, 0);
    test_half(1'b0);
    test_half(1'b1);
    test_wrap();
    test_unity("stall", 1'b1, 0);
    test_unity("midstart", 1'b0, 1);
    test_unity("laststart", 1'b0, 2);
    test_overflow();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
